seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIGITS, default 8, number of multiplexed digits (legal 1..8).
REQ-002 Parameter SCAN_DIV, default 100000, clk cycles per digit slot (legal >= 4).
REQ-003 Parameter BLANK_CYC, default 2, anti-ghost cycles at start of each slot (legal 0..SCAN_DIV-2).
REQ-004 Parameter BLINK_FRAMES, default 64, frames per blink half-period (legal >= 1).
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 cs  input  1  capture strobe for i_data, i_dp, mode.
REQ-008 i_data  input  4*DIGITS  hex nibbles; digit k = i_data[4k+3:4k], digit 0 rightmost.
REQ-009 i_dp  input  DIGITS  decimal point per digit, 1 = lit.
REQ-010 mode  input  2  bit0 leading-zero suppression, bit1 blink enable.
REQ-011 o_seg  output  8  active-low segments; bit0..6 = a..g, bit7 = dp.
REQ-012 o_sel  output  DIGITS  active-low digit select, one-hot-low when driven.
REQ-013 o_frame  output  1  one-cycle pulse on last cycle of digit DIGITS-1 slot.

Function
REQ-014 Scan counter counts 0..SCAN_DIV-1 then wraps to 0; digit index advances on wrap, DIGITS-1 -> 0.
REQ-015 cs=1 on an edge SHALL load i_data, i_dp, mode into a pending register and set pending flag; later cs overwrites pending.
REQ-016 Pending SHALL transfer to display register only on the edge where digit index wraps DIGITS-1 -> 0; flag then clears (no mid-frame tearing).
REQ-017 cs asserted on the transfer edge itself SHALL load pending and keep flag set; transfer uses the old pending value.
REQ-018 Latency: value captured by cs becomes visible from the first slot of digit 0 after the next frame wrap (at most one frame + 1 cycle).
REQ-019 During scan counts 0..BLANK_CYC-1 of each slot, o_sel SHALL be all-ones and o_seg 8'hFF.
REQ-020 Otherwise o_sel SHALL drive bit of current digit low, all others high; o_seg = hex pattern of current nibble plus dp.
REQ-021 Hex patterns (gfedcba, active-low): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E.
REQ-022 Leading-zero suppression: digit k blanked (segments a..g off) when all nibbles k..DIGITS-1 are 0 and k != 0; dp still honoured; digit 0 never suppressed.
REQ-023 Frame counter counts completed frames modulo BLINK_FRAMES; blink phase toggles on its wrap.
REQ-024 Blink enabled and phase=1: o_sel all-ones, o_seg 8'hFF for entire frames; blink disabled: phase ignored, counter keeps running.
REQ-025 o_frame SHALL pulse exactly once per frame, independent of blanking, blink, cs.
REQ-026 Outputs SHALL be registered (one-cycle pipeline from counters); no combinational path from inputs to outputs.
REQ-027 DIGITS=1: index stays 0, every slot wrap is a frame wrap.

Reset
REQ-028 reset low SHALL immediately force o_seg=8'hFF, o_sel all-ones, o_frame=0, counters, blink phase, pending flag, pending and display registers to 0, independent of clk.
REQ-029 Release SHALL be sampled synchronously; first slot after release is digit 0, scan count 0.
REQ-030 Reset mid-frame with pending flag set SHALL discard pending data; display shows "0" on digit 0 only if mode bit0 re-captured, otherwise all 0 digits.

Verification (DIGITS=8, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2)
REQ-031 Reset, cs with i_data=32'h1234ABCD, mode=0 -> after next frame wrap digit0 o_seg=8'hA1, digit7 o_seg=8'hF9, o_sel cycles FE,FD..7F, each slot blanked 1 cycle.
REQ-032 i_data=32'h0000_00F0, mode=01 -> digits 2..7 segments off, digit1 8'h8E, digit0 8'hC0; i_dp=8'h04 -> digit2 o_seg=8'h7F.
REQ-033 cs pulses mid-frame with 32'h11111111 then 32'h22222222 -> no change until wrap, then only 22222222 shown, never 1s.
REQ-034 mode=10 -> frames 0-1 displayed, frames 2-3 o_sel=FF, o_frame pulses every 32 cycles throughout.
REQ-035 reset asserted mid-slot between clk edges -> outputs FF/FF same instant; pending discarded, post-release o_sel=FE after blank cycle, display 0s.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Host-side capture bus and display-side outputs of the 7-segment scanner.
interface seg7_scan_if #(
    parameter int DIGITS = 8
);
    logic                  cs;
    logic [4*DIGITS-1:0]   i_data;
    logic [DIGITS-1:0]     i_dp;
    logic [1:0]            mode;
    logic [7:0]            o_seg;
    logic [DIGITS-1:0]     o_sel;
    logic                  o_frame;

    modport master (
        output cs, i_data, i_dp, mode,
        input  o_seg, o_sel, o_frame
    );

    modport slave (
        input  cs, i_data, i_dp, mode,
        output o_seg, o_sel, o_frame
    );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed hex 7-segment scanner with frame-synchronous update,
// anti-ghost blanking, leading-zero suppression and frame-based blink.
module seg7_scan #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    seg7_scan_if.slave  bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic [4*DIGITS-1:0] data;
        logic [DIGITS-1:0]   dp;
        logic [1:0]          mode;
    } disp_t;

    logic [CW-1:0]     scan_cnt;
    logic [IW-1:0]     dig_idx;
    logic [FW-1:0]     frame_cnt;
    logic              blink_phase;
    disp_t             pend, disp;
    logic              pend_flag;
    logic              slot_wrap, last_dig, frame_wrap;

    logic [DIGITS-1:0] nz_above;
    logic [3:0]        cur_nib;
    logic              cur_dp, suppress, dark;
    logic [7:0]        seg_nxt, seg_q;
    logic [DIGITS-1:0] sel_nxt, sel_q;
    logic              frame_q;

    assign slot_wrap  = (scan_cnt == CW'(SCAN_DIV - 1));
    assign last_dig   = (dig_idx == IW'(DIGITS - 1));
    assign frame_wrap = slot_wrap && last_dig;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt    <= '0;
            dig_idx     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (slot_wrap) begin
                scan_cnt <= '0;
                dig_idx  <= last_dig ? '0 : dig_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (frame_wrap) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // A cs on the wrap edge refills pending while the old pending moves out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend      <= '0;
            disp      <= '0;
            pend_flag <= 1'b0;
        end else begin
            if (frame_wrap && pend_flag)
                disp <= pend;
            if (bus.cs) begin
                pend      <= '{data: bus.i_data, dp: bus.i_dp, mode: bus.mode};
                pend_flag <= 1'b1;
            end else if (frame_wrap) begin
                pend_flag <= 1'b0;
            end
        end
    end

    // nz_above[k]: some nibble in k..DIGITS-1 is non-zero.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        nz_above = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc         = acc | (disp.data[4*k +: 4] != 4'h0);
            nz_above[k] = acc;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    assign cur_nib  = disp.data[4*int'(dig_idx) +: 4];
    assign cur_dp   = disp.dp[dig_idx];
    assign suppress = disp.mode[0] && (dig_idx != '0) && !nz_above[dig_idx];
    assign dark     = (int'(scan_cnt) < BLANK_CYC) || (disp.mode[1] && blink_phase);

    always_comb begin
        sel_nxt = '1;
        seg_nxt = 8'hFF;
        if (!dark) begin
            sel_nxt[dig_idx] = 1'b0;
            seg_nxt          = {~cur_dp, suppress ? 7'h7F : hex7(cur_nib)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q   <= 8'hFF;
            sel_q   <= '1;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_nxt;
            sel_q   <= sel_nxt;
            frame_q <= frame_wrap;
        end
    end

    assign bus.o_seg   = seg_q;
    assign bus.o_sel   = sel_q;
    assign bus.o_frame = frame_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: DIGITS=8, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.
module tb_seg7_scan;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_pass = 0;
    int   pos = 0;   // output cycles since reset release

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_if #(.DIGITS(8)) bus ();

    seg7_scan #(
        .DIGITS(8), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    function automatic logic [7:0] seg_of(input logic [31:0] d, input logic [7:0] dp,
                                          input logic [1:0] m, input int k);
        logic [31:0] hi;
        logic [6:0]  g;
        hi = d >> (4*k);
        g  = (m[0] && k != 0 && hi == 32'h0) ? 7'h7F : HEX[hi[3:0]];
        return {~dp[k], g};
    endfunction

    task automatic chk_cycle(input logic [31:0] d, input logic [7:0] dp, input logic [1:0] m);
        int j, idx, cnt, f;
        logic dark;
        logic [7:0] es, eg;
        j    = pos - 1;
        idx  = (j % 32) / 4;
        cnt  = j % 4;
        f    = j / 32;
        dark = (cnt == 0) || (m[1] && ((f / 2) % 2 == 1));
        es   = dark ? 8'hFF : ~(8'h01 << idx);
        eg   = dark ? 8'hFF : seg_of(d, dp, m, idx);
        check($sformatf("sel@%0d", pos), 32'(bus.o_sel), 32'(es));
        check($sformatf("seg@%0d", pos), 32'(bus.o_seg), 32'(eg));
        check($sformatf("frm@%0d", pos), 32'(bus.o_frame), 32'(pos % 32 == 0));
    endtask

    task automatic run_to(input int target, input logic [31:0] d, input logic [7:0] dp,
                          input logic [1:0] m);
        while (pos < target) begin
            @(posedge clk);
            #1;
            pos++;
            chk_cycle(d, dp, m);
        end
    endtask

    task automatic cs_on(input logic [31:0] d, input logic [7:0] dp, input logic [1:0] m);
        bus.cs     = 1'b1;
        bus.i_data = d;
        bus.i_dp   = dp;
        bus.mode   = m;
    endtask

    localparam logic [31:0] D1 = 32'h1234ABCD;
    localparam logic [31:0] D2 = 32'h22222222;
    localparam logic [31:0] DA = 32'h00000300;
    localparam logic [31:0] DB = 32'h00000077;
    localparam logic [31:0] DC = 32'h000000F0;
    localparam logic [31:0] DE = 32'h00000009;

    initial begin
        reset      = 1'b0;
        bus.cs     = 1'b0;
        bus.i_data = '0;
        bus.i_dp   = '0;
        bus.mode   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", 32'(bus.o_seg), 32'hFF);
        check("rst_sel", 32'(bus.o_sel), 32'hFF);
        check("rst_frm", 32'(bus.o_frame), 32'h0);
        #3 reset = 1'b1;
        pos = 0;

        // reset display is all zeros; capture D1 inside frame 0
        run_to(2, 0, 0, 0);
        cs_on(D1, 8'h00, 2'b00);
        run_to(3, 0, 0, 0);
        bus.cs = 1'b0;
        run_to(32, 0, 0, 0);
        run_to(34, D1, 0, 0);
        check("d0_A1", 32'(bus.o_seg), 32'hA1);
        run_to(62, D1, 0, 0);
        check("d7_F9", 32'(bus.o_seg), 32'hF9);

        // two mid-frame captures: only the last one appears, at the wrap
        run_to(70, D1, 0, 0);
        cs_on(32'h11111111, 8'h00, 2'b00);
        run_to(71, D1, 0, 0);
        bus.cs = 1'b0;
        run_to(75, D1, 0, 0);
        cs_on(D2, 8'h00, 2'b00);
        run_to(76, D1, 0, 0);
        bus.cs = 1'b0;
        run_to(96, D1, 0, 0);
        run_to(119, D2, 0, 0);

        // capture before the wrap, then again on the wrap edge itself
        cs_on(DA, 8'h00, 2'b01);
        run_to(120, D2, 0, 0);
        bus.cs = 1'b0;
        run_to(127, D2, 0, 0);
        cs_on(DB, 8'h00, 2'b00);
        run_to(128, D2, 0, 0);
        bus.cs = 1'b0;
        run_to(160, DA, 0, 2'b01);
        run_to(165, DB, 0, 2'b00);

        // leading-zero suppression with a decimal point on a suppressed digit
        cs_on(DC, 8'h04, 2'b01);
        run_to(166, DB, 0, 2'b00);
        bus.cs = 1'b0;
        run_to(192, DB, 0, 2'b00);
        run_to(194, DC, 8'h04, 2'b01);
        check("lz_d0", 32'(bus.o_seg), 32'hC0);
        run_to(198, DC, 8'h04, 2'b01);
        check("lz_d1", 32'(bus.o_seg), 32'h8E);
        run_to(202, DC, 8'h04, 2'b01);
        check("lz_d2dp", 32'(bus.o_seg), 32'h7F);

        // blink: two frames lit, two frames dark
        run_to(210, DC, 8'h04, 2'b01);
        cs_on(DE, 8'h00, 2'b10);
        run_to(211, DC, 8'h04, 2'b01);
        bus.cs = 1'b0;
        run_to(224, DC, 8'h04, 2'b01);
        run_to(290, DE, 0, 2'b10);
        check("blink_on", 32'(bus.o_seg), 32'h90);
        run_to(330, DE, 0, 2'b10);
        check("blink_off", 32'(bus.o_sel), 32'hFF);

        // reset between edges with a capture still pending
        run_to(387, DE, 0, 2'b10);
        cs_on(32'h87654321, 8'hFF, 2'b01);
        run_to(388, DE, 0, 2'b10);
        bus.cs = 1'b0;
        run_to(390, DE, 0, 2'b10);
        #2 reset = 1'b0;
        #1;
        check("arst_seg", 32'(bus.o_seg), 32'hFF);
        check("arst_sel", 32'(bus.o_sel), 32'hFF);
        check("arst_frm", 32'(bus.o_frame), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("hold_sel", 32'(bus.o_sel), 32'hFF);
        #3 reset = 1'b1;
        pos = 0;
        run_to(2, 0, 0, 0);
        check("post_sel", 32'(bus.o_sel), 32'hFE);
        run_to(64, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
